// File: rtl/ps2_scan_receiver_pkg.sv
// Shared PS/2 definitions: receiver FSM states, prefix bytes and stopwatch command scan codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] KEY_START = 8'h1B;
    localparam logic [7:0] KEY_PAUSE = 8'h4D;
    localparam logic [7:0] KEY_RESET = 8'h2D;

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Scan-code output bundle from the PS/2 receiver to the command decoder.
interface ps2_scan_receiver_if;
    logic [7:0] code;
    logic       code_valid;
    logic       code_break;
    logic       code_ext;
    logic       frame_err;

    modport master (output code, code_valid, code_break, code_ext, frame_err);
    modport slave  (input  code, code_valid, code_break, code_ext, frame_err);
endinterface

// File: rtl/ps2_input_filter.sv
// Synchronizer plus glitch filter for one raw PS/2 pin; outputs the accepted level and a 1->0 pulse.
module ps2_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_fall;
    logic                   w_synced;
    logic                   w_differs;
    logic                   w_accept;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_synced != r_level);
    assign w_accept  = w_differs && (r_cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: chain and level preset to the idle-high pin state so leaving reset never fakes a falling edge.
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_fall <= w_accept && !w_synced;
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_level <= w_synced;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 frame receiver: 11-bit frame assembly, odd-parity/stop check, inter-edge timeout.
// Optional PS2_BREAK_FILTER_EN folds F0/E0 prefixes into code_break/code_ext instead of emitting them.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_scan_receiver_if.master   bus
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES);

    ps2_state_t   r_state;
    ps2_state_t   w_next_state;
    logic [7:0]   r_shift;
    logic [2:0]   r_bit_cnt;
    logic         r_parity;
    logic [TW-1:0] r_tmo_cnt;
    logic [7:0]   r_code;
    logic         r_code_valid;
    logic         r_frame_err;
    logic         w_clk_fall;
    logic         w_clk_level_unused;
    logic         w_data;
    logic         w_data_fall_unused;
    logic         w_timeout;
    logic         w_good;
    logic         w_bad;

    ps2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock   (clock),
        .reset   (reset),
        .i_pin   (ps2_clk),
        .o_level (w_clk_level_unused),
        .o_fall  (w_clk_fall)
    );

    ps2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clock   (clock),
        .reset   (reset),
        .i_pin   (ps2_data),
        .o_level (w_data),
        .o_fall  (w_data_fall_unused)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        // A falling edge in the expiry cycle wins: the frame is still alive.
        w_timeout    = (r_state != IDLE) && !w_clk_fall && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_next_state = IDLE;
            w_bad        = 1'b1;
        end else if (w_clk_fall) begin
            case (r_state)
                IDLE:    if (!w_data) w_next_state = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_next_state = PARITY;
                PARITY:  w_next_state = STOP;
                STOP: begin
                    w_next_state = IDLE;
                    if (w_data && (^{r_shift, r_parity})) w_good = 1'b1;
                    else                                  w_bad  = 1'b1;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic r_code_break;
    logic r_code_ext;
    logic r_pend_break;
    logic r_pend_ext;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_parity     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            r_code_break <= 1'b0;
            r_code_ext   <= 1'b0;
            r_pend_break <= 1'b0;
            r_pend_ext   <= 1'b0;
`endif
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= w_bad;

            if (r_state == IDLE || w_clk_fall || w_timeout) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_clk_fall) begin
                case (r_state)
                    IDLE:    r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY:  r_parity <= w_data;
                    default: ;
                endcase
            end

`ifdef PS2_BREAK_FILTER_EN
            if (w_good) begin
                if (r_shift == PS2_BREAK) begin
                    r_pend_break <= 1'b1;
                end else if (r_shift == PS2_EXT) begin
                    r_pend_ext <= 1'b1;
                end else begin
                    r_code_valid <= 1'b1;
                    r_code       <= r_shift;
                    r_code_break <= r_pend_break;
                    r_code_ext   <= r_pend_ext;
                    r_pend_break <= 1'b0;
                    r_pend_ext   <= 1'b0;
                end
            end
            if (w_bad && !w_timeout) begin
                r_pend_break <= 1'b0;
                r_pend_ext   <= 1'b0;
            end
`else
            if (w_good) begin
                r_code_valid <= 1'b1;
                r_code       <= r_shift;
            end
`endif
        end
    end

    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;
`ifdef PS2_BREAK_FILTER_EN
    assign bus.code_break = r_code_break;
    assign bus.code_ext   = r_code_ext;
`else
    assign bus.code_break = 1'b0;
    assign bus.code_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver; time base scaled to 1 MHz so 1 us = 1 clock and a 60 us PS/2 bit = 60 clocks.
module tb_ps2_scan_receiver;

    // Raw-fall to output latency: SYNC_STAGES(2) + FILTER_LEN(8) + 1 = 11 cycles.
    localparam int LAT_VALID = 11;
    // Raw fall to timeout frame_err: 11 + 2000 cycles of 2 ms at 1 MHz.
    localparam int LAT_TMO   = 2011;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(
        .CLK_HZ      (1_000_000),
        .TIMEOUT_US  (2000),
        .SYNC_STAGES (2),
        .FILTER_LEN  (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_valid  = 0;
    int         n_err    = 0;
    int         n_viol   = 0;
    int         last_fall_cyc  = 0;
    int         last_valid_cyc = 0;
    int         last_err_cyc   = 0;
    logic [7:0] last_code  = 8'h00;
    logic       last_break = 1'b0;
    logic       last_ext   = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] code_q[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.code_valid) begin
                n_valid++;
                last_code      = bus.code;
                last_break     = bus.code_break;
                last_ext       = bus.code_ext;
                last_valid_cyc = cyc;
                code_q.push_back(bus.code);
            end
            if (bus.frame_err) begin
                n_err++;
                last_err_cyc = cyc;
            end
            if (bus.code_valid && bus.frame_err) n_viol++;
            if (bus.code_valid && prev_valid)    n_viol++;
        end
        prev_valid = bus.code_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Bits go out LSB first; data changes at the clock-high midpoint. A glitch of 7 low cycles
    // can be placed in the high phase of bit glitch_bit.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(15);
            ps2_data = f[i];
            if (i == glitch_bit) begin
                wait_cyc(2);
                ps2_clk = 1'b0;
                wait_cyc(7);
                ps2_clk = 1'b1;
                wait_cyc(6);
            end else begin
                wait_cyc(15);
            end
            ps2_clk       = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(30);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(60);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    int v0;
    int e0;

    initial begin
        wait_cyc(5);
        check("reset_code",  {24'd0, bus.code},  32'h00);
        check("reset_flags", {28'd0, bus.code_valid, bus.code_break, bus.code_ext, bus.frame_err}, 32'h0);
        reset = 1'b0;
        wait_cyc(20);

        // 1: plain 0x1B
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1B, 1'b1, 1'b1, 11, -1);
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_err_cnt",   n_err - e0,   0);
        check("t1_code",      last_code,    8'h1B);
        check("t1_flags",     {last_break, last_ext}, 2'b00);
        check("t1_latency",   last_valid_cyc - last_fall_cyc, LAT_VALID);

        // 2: F0 then 1B
        v0 = n_valid; e0 = n_err;
        code_q.delete();
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        send_frame(8'h1B, 1'b1, 1'b1, 11, -1);
        check("t2_err_cnt", n_err - e0, 0);
`ifdef PS2_BREAK_FILTER_EN
        check("t2_valid_cnt", n_valid - v0, 1);
        check("t2_code",      last_code,    8'h1B);
        check("t2_flags",     {last_break, last_ext}, 2'b10);
`else
        check("t2_valid_cnt", n_valid - v0, 2);
        if (code_q.size() == 2) begin
            check("t2_first",  code_q[0], 8'hF0);
            check("t2_second", code_q[1], 8'h1B);
        end else begin
            check("t2_queue_len", code_q.size(), 2);
        end
        check("t2_flags", {last_break, last_ext}, 2'b00);
`endif

        // 3: 0x4D with wrong parity
        v0 = n_valid; e0 = n_err;
        send_frame(8'h4D, 1'b0, 1'b1, 11, -1);
        check("t3_err_cnt",   n_err - e0,   1);
        check("t3_valid_cnt", n_valid - v0, 0);
        check("t3_err_lat",   last_err_cyc - last_fall_cyc, LAT_VALID);
        check("t3_code_held", {24'd0, bus.code}, 32'h1B);

        // 4: truncated frame then idle past the timeout, then 0x2D
        v0 = n_valid; e0 = n_err;
        send_frame(8'h2D, 1'b1, 1'b1, 6, -1);
        wait_cyc(3000);
        check("t4_err_cnt",   n_err - e0,   1);
        check("t4_valid_cnt", n_valid - v0, 0);
        check("t4_tmo_lat",   last_err_cyc - last_fall_cyc, LAT_TMO);
        send_frame(8'h2D, 1'b1, 1'b1, 11, -1);
        check("t4_code",       last_code,    8'h2D);
        check("t4_valid_cnt2", n_valid - v0, 1);
        check("t4_err_cnt2",   n_err - e0,   1);

        // 5: short ps2_clk glitch inside bit 4 of 0x1B
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1B, 1'b1, 1'b1, 11, 4);
        check("t5_valid_cnt", n_valid - v0, 1);
        check("t5_err_cnt",   n_err - e0,   0);
        check("t5_code",      last_code,    8'h1B);

        // 6: E0, reset, reset mid-frame, then 0x4D
        v0 = n_valid; e0 = n_err;
        send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
`ifdef PS2_BREAK_FILTER_EN
        check("t6_e0_valid", n_valid - v0, 0);
`else
        check("t6_e0_valid", n_valid - v0, 1);
        check("t6_e0_code",  last_code,    8'hE0);
`endif
        pulse_reset();
        check("t6_reset_code", {24'd0, bus.code}, 32'h00);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h4D, 1'b1, 1'b1, 4, -1);
        pulse_reset();
        wait_cyc(3000);
        check("t6_mid_valid", n_valid - v0, 0);
        check("t6_mid_err",   n_err - e0,   0);
        send_frame(8'h4D, 1'b1, 1'b1, 11, -1);
        check("t6_valid_cnt", n_valid - v0, 1);
        check("t6_code",      last_code,    8'h4D);
        check("t6_flags",     {last_break, last_ext}, 2'b00);

        check("pulse_rules", n_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
